// File: rtl/bdl_dma_fetch_pkg.sv
// Shared definitions for the BDL DMA fetch/writeback initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bdl_dma_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WB   = 3'd3,
        S_BRD  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // Descriptor word indices inside the BDL
    localparam logic [2:0] BDL_FLAG = 3'd0;
    localparam logic [2:0] BDL_ADRH = 3'd1;
    localparam logic [2:0] BDL_ADRL = 3'd2;
    localparam logic [2:0] BDL_LEN  = 3'd3;
    localparam logic [2:0] BDL_ST1  = 3'd4;
    localparam logic [2:0] BDL_ST2  = 3'd5;

    // Flag bit positions in the address-high word
    localparam int FLAG_V = 15;
    localparam int FLAG_C = 14;

    // Written into the flag word on writeback: descriptor in use / used
    localparam logic [15:0] BDL_IN_USE = 16'hC000;

    // Writeback order 0 -> 5 -> 4 so that status-1 reaches memory last
    function automatic logic [2:0] wb_next_idx(input logic [2:0] idx);
        case (idx)
            BDL_FLAG: return BDL_ST2;
            BDL_ST2:  return BDL_ST1;
            default:  return BDL_FLAG;
        endcase
    endfunction

endpackage

// File: rtl/bdl_dma_fetch_tmo.sv
// Memory-cycle watchdog: reloads on each strobe rise, pulses tmo_o on the last allowed cycle.
// Latency: combinational pulse in the TMO-th strobe cycle (rise cycle counts as the first).
// Backpressure: none; purely observes the strobe.
module bdl_dma_fetch_tmo #(
    parameter int TMO = 255,
    parameter int W   = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic stb_i,
    output logic tmo_o
);
    logic         r_stb_d;
    logic [W-1:0] r_cnt;
    logic         w_rise;
    logic [W-1:0] w_rem;

    assign w_rise = stb_i & ~r_stb_d;
    assign w_rem  = w_rise ? W'(TMO - 1) : r_cnt;
    assign tmo_o  = stb_i & (w_rem == '0);

    // Remember the strobe for edge detection and count down while it is held
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_stb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_stb_d <= stb_i;
            if (stb_i && (w_rem != '0)) begin
                r_cnt <= w_rem - W'(1);
            end
        end
    end

endmodule

// File: rtl/bdl_dma_fetch.sv
// DMA initiator moving one 6-word descriptor memory->BDL, or status words BDL->memory (optional chain follow: BDL_CHAIN_EN).
// Latency: 1 cycle REQ + grant wait, then per word RD(until ack)+WB, or BRD(2)+WR(until ack); 1 DONE cycle.
// Backpressure: mem_stb_o held until mem_ack_i or watchdog expiry; start_i ignored while busy or in DONE.
module bdl_dma_fetch
    import bdl_dma_fetch_pkg::*;
#(
    parameter int NUM    = 6,
    parameter int AW     = 22,
    parameter int TMO    = 255,
    parameter int MAXCHN = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          start_i,
    input  logic          op_i,
    input  logic [AW-1:0] base_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          valid_o,
    output logic          chn_o,
    output logic          dma_req_o,
    input  logic          dma_gnt_i,
    output logic [AW-1:0] mem_adr_o,
    output logic [15:0]   mem_dat_o,
    input  logic [15:0]   mem_dat_i,
    output logic          mem_we_o,
    output logic          mem_stb_o,
    input  logic          mem_ack_i,
    output logic [2:0]    bdl_adr_o,
    output logic [15:0]   bdl_dat_o,
    input  logic [15:0]   bdl_dat_i,
    output logic          bdl_we_o,
    output logic          bdl_stb_o
);
    localparam logic [2:0] LAST_IDX = 3'(NUM - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_op;
    logic [AW-1:0] r_base;
    logic [2:0]    r_idx;
    logic [15:0]   r_dat;
    logic          r_err;
    logic          r_valid;
    logic          r_chn;
    logic          r_brd2;
    logic          w_mem_phase;
    logic          w_tmo;
    logic          w_chain;
    logic          w_chain_err;
`ifdef BDL_CHAIN_EN
    logic [5:0]    r_w1lo;
    logic [3:0]    r_hops;
`endif

    assign w_mem_phase = (r_state == S_RD) || (r_state == S_WR);
    assign mem_stb_o   = w_mem_phase;
    assign mem_we_o    = (r_state == S_WR);
    assign mem_adr_o   = w_mem_phase ? (r_base + AW'({r_idx, 1'b0})) : '0;
    assign mem_dat_o   = (r_state == S_WR) ? r_dat : 16'h0000;
    assign bdl_adr_o   = bdl_stb_o ? r_idx : 3'd0;
    assign bdl_dat_o   = bdl_we_o ? r_dat : 16'h0000;
    assign err_o       = r_err;
    assign valid_o     = r_valid;
    assign chn_o       = r_chn;

    bdl_dma_fetch_tmo #(
        .TMO (TMO),
        .W   (8)
    ) u_tmo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .stb_i    (w_mem_phase),
        .tmo_o    (w_tmo)
    );

    // Next-state and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        dma_req_o   = 1'b0;
        bdl_stb_o   = 1'b0;
        bdl_we_o    = 1'b0;
        w_chain     = 1'b0;
        w_chain_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                busy_o    = 1'b1;
                dma_req_o = 1'b1;
                if (dma_gnt_i) w_state_nxt = r_op ? S_BRD : S_RD;
            end
            S_RD: begin
                busy_o    = 1'b1;
                dma_req_o = 1'b1;
                if (mem_ack_i)  w_state_nxt = S_WB;
                else if (w_tmo) w_state_nxt = S_DONE;
            end
            S_WB: begin
                busy_o    = 1'b1;
                dma_req_o = 1'b1;
                bdl_stb_o = 1'b1;
                bdl_we_o  = 1'b1;
                if ((r_idx == BDL_ADRH) && !r_dat[FLAG_V]) begin
                    w_state_nxt = S_DONE;
                end else if ((r_idx == BDL_ADRL) && r_chn) begin
`ifdef BDL_CHAIN_EN
                    if (r_hops == 4'(MAXCHN)) begin
                        w_chain_err = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_chain     = 1'b1;
                        w_state_nxt = S_RD;
                    end
`else
                    // Chain left to firmware: stop once the link words are in the BDL
                    w_state_nxt = S_DONE;
`endif
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_BRD: begin
                busy_o    = 1'b1;
                dma_req_o = 1'b1;
                bdl_stb_o = 1'b1;
                if (r_brd2) w_state_nxt = S_WR;
            end
            S_WR: begin
                busy_o    = 1'b1;
                dma_req_o = 1'b1;
                if (mem_ack_i)  w_state_nxt = (r_idx == BDL_ST1) ? S_DONE : S_BRD;
                else if (w_tmo) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus word index, data latch and status flags
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            r_base  <= '0;
            r_idx   <= 3'd0;
            r_dat   <= 16'h0000;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_chn   <= 1'b0;
            r_brd2  <= 1'b0;
`ifdef BDL_CHAIN_EN
            r_w1lo  <= 6'd0;
            r_hops  <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op    <= op_i;
                        r_base  <= {base_i[AW-1:1], 1'b0};
                        r_idx   <= 3'd0;
                        r_err   <= 1'b0;
                        r_valid <= 1'b0;
                        r_chn   <= 1'b0;
                        r_brd2  <= 1'b0;
`ifdef BDL_CHAIN_EN
                        r_hops  <= 4'd0;
`endif
                    end
                end
                S_RD: begin
                    if (mem_ack_i)  r_dat <= mem_dat_i;
                    else if (w_tmo) r_err <= 1'b1;
                end
                S_WB: begin
                    if (r_idx == BDL_ADRH) begin
                        r_valid <= r_dat[FLAG_V];
                        r_chn   <= r_dat[FLAG_C];
`ifdef BDL_CHAIN_EN
                        r_w1lo  <= r_dat[5:0];
`endif
                    end
                    if (w_chain) begin
`ifdef BDL_CHAIN_EN
                        r_base <= AW'({r_w1lo, r_dat[15:1], 1'b0});
                        r_hops <= r_hops + 4'd1;
`endif
                        r_idx  <= 3'd0;
                    end else if (w_state_nxt == S_RD) begin
                        r_idx <= r_idx + 3'd1;
                    end
                    if (w_chain_err) r_err <= 1'b1;
                end
                S_BRD: begin
                    r_brd2 <= ~r_brd2;
                    // Second read cycle: regf output is settled even if registered
                    if (r_brd2) begin
                        r_dat <= (r_idx == BDL_FLAG) ? (bdl_dat_i | BDL_IN_USE) : bdl_dat_i;
                    end
                end
                S_WR: begin
                    if (mem_ack_i)  r_idx <= wb_next_idx(r_idx);
                    else if (w_tmo) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
